// File: rtl/demux_nxm_striper_pkg.sv
// Shared helpers for the N-channel round-robin byte striper:
// selector width derivation and flattened output indexing.
package demux_pkg;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Selector is never narrower than one bit, even for degenerate fanouts.
    function automatic int sel_width(input int fanout);
        return (clog2(fanout) < 1) ? 1 : clog2(fanout);
    endfunction

    function automatic int idx(input int i, input int j, input int fanout);
        return i * fanout + j;
    endfunction

endpackage

// File: rtl/demux_nxm_striper_demux1xn_rr.sv
// One input channel demuxed round-robin onto FANOUT registered byte outputs,
// with a shared lane-realign input that forces the next byte onto output 0.
module demux1xn_rr
    import demux_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int FANOUT = 2,
    localparam int SEL_W  = sel_width(FANOUT)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    in_valid,
    input  logic                    align,
    output logic [FANOUT*WIDTH-1:0] out_data,
    output logic [FANOUT-1:0]       out_valid,
    output logic [SEL_W-1:0]        sel,
    output logic [SEL_W-1:0]        sel_next
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(FANOUT - 1);

    logic [FANOUT-1:0][WIDTH-1:0] out_q, out_d;
    logic [FANOUT-1:0]            vld_q, vld_d;
    logic [SEL_W-1:0]             sel_q, sel_d;
    logic [SEL_W-1:0]             target;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        target = align ? '0 : sel_q;
        sel_d  = sel_q;
        out_d  = out_q;
        vld_d  = '0;
        if (in_valid) begin
            out_d[target] = in_data;
            vld_d[target] = 1'b1;
            // Explicit wrap so non-power-of-two fanouts never reach FANOUT.
            sel_d = (target == LAST) ? '0 : target + SEL_W'(1);
        end else if (align) begin
            sel_d = '0;
        end
    end

    // NOTE: the output byte registers are architectural state that must read zero out of reset, so they are reset like control flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q <= '0;
            vld_q <= '0;
            sel_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of statement order.
            out_q <= out_d;
            vld_q <= vld_d;
            sel_q <= sel_d;
        end
    end

    assign out_data  = out_q;
    assign out_valid = vld_q;
    assign sel       = sel_q;
    assign sel_next  = sel_d;

    sel_in_range_a: assert property (@(posedge clk) disable iff (!reset) sel_q <= LAST);

endmodule

// File: rtl/demux_nxm_striper.sv
// NUM_IN independent round-robin byte demuxes with a shared realign input and
// a registered flag raised when the channel selectors drift apart.
module demux_nxm_striper
    import demux_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int NUM_IN = 2,
    parameter  int FANOUT = 2,
    localparam int SEL_W  = sel_width(FANOUT)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_IN*WIDTH-1:0]        in,
    input  logic [NUM_IN-1:0]              valid,
    input  logic                           align,
    output logic [NUM_IN*FANOUT*WIDTH-1:0] out,
    output logic [NUM_IN*FANOUT-1:0]       validout,
    output logic [NUM_IN*SEL_W-1:0]        sel,
    output logic                           skew
);

    logic [SEL_W-1:0] sel_nxt [NUM_IN];
    logic             skew_q, skew_d;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_ch
        demux1xn_rr #(
            .WIDTH  (WIDTH),
            .FANOUT (FANOUT)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .in_data   (in[g*WIDTH +: WIDTH]),
            .in_valid  (valid[g]),
            .align     (align),
            .out_data  (out[idx(g, 0, FANOUT)*WIDTH +: FANOUT*WIDTH]),
            .out_valid (validout[idx(g, 0, FANOUT) +: FANOUT]),
            .sel       (sel[g*SEL_W +: SEL_W]),
            .sel_next  (sel_nxt[g])
        );
    end

    // Compare next-state selectors so the flag lines up with the registered sel.
    always_comb begin
        skew_d = 1'b0;
        for (int i = 1; i < NUM_IN; i++) begin
            if (sel_nxt[i] != sel_nxt[0]) skew_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) skew_q <= 1'b0;
        else        skew_q <= skew_d;
    end

    assign skew = skew_q;

endmodule

// File: tb/tb_demux_nxm_striper.sv
// Directed bench: default 2x2 striper for round-robin, gaps, skew, align and
// reset; a 3x3 instance for the non-power-of-two wrap.
module tb_demux_nxm_striper;

    logic        clk;
    logic        reset;
    logic        align;

    logic [15:0] in_a;
    logic [1:0]  valid_a;
    logic [31:0] out_a;
    logic [3:0]  vo_a;
    logic [1:0]  sel_a;
    logic        skew_a;

    logic [23:0] in_b;
    logic [2:0]  valid_b;
    logic [71:0] out_b;
    logic [8:0]  vo_b;
    logic [5:0]  sel_b;
    logic        skew_b;

    int total = 0;
    int bad   = 0;

    demux_nxm_striper #(.WIDTH(8), .NUM_IN(2), .FANOUT(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in_a),
        .valid    (valid_a),
        .align    (align),
        .out      (out_a),
        .validout (vo_a),
        .sel      (sel_a),
        .skew     (skew_a)
    );

    demux_nxm_striper #(.WIDTH(8), .NUM_IN(3), .FANOUT(3)) dut3 (
        .clk      (clk),
        .reset    (reset),
        .in       (in_b),
        .valid    (valid_b),
        .align    (align),
        .out      (out_b),
        .validout (vo_b),
        .sel      (sel_b),
        .skew     (skew_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic [31:0] o, input logic [3:0] v,
                           input logic [1:0] s, input logic k);
        check({tag, ".out"},   64'(out_a), 64'(o));
        check({tag, ".vout"},  64'(vo_a),  64'(v));
        check({tag, ".sel"},   64'(sel_a), 64'(s));
        check({tag, ".skew"},  64'(skew_a), 64'(k));
    endtask

    initial begin
        reset   = 1'b1;
        align   = 1'b0;
        in_a    = '0;
        valid_a = '0;
        in_b    = '0;
        valid_b = '0;
        #1 reset = 1'b0;
        #1;
        check_a("por", 32'h0, 4'h0, 2'b00, 1'b0);
        step();
        step();
        reset = 1'b1;

        // Round-robin on channel 0: A1 -> out0, A2 -> out1, A3 -> out0.
        in_a = 16'h00A1; valid_a = 2'b01; step();
        check_a("rr1", 32'h0000_00A1, 4'b0001, 2'b01, 1'b1);
        in_a = 16'h00A2; step();
        check_a("rr2", 32'h0000_A2A1, 4'b0010, 2'b00, 1'b0);
        in_a = 16'h00A3; step();
        check_a("rr3", 32'h0000_A2A3, 4'b0001, 2'b01, 1'b1);

        // Align with no valid byte returns every selector to 0.
        valid_a = 2'b00; align = 1'b1; step();
        check_a("align_novalid", 32'h0000_A2A3, 4'b0000, 2'b00, 1'b0);
        align = 1'b0;

        // Gapped valid: 0x10, idle (sel holds at 1), 0x20 onto out1.
        in_a = 16'h0010; valid_a = 2'b01; step();
        check_a("gap1", 32'h0000_A210, 4'b0001, 2'b01, 1'b1);
        in_a = 16'h00EE; valid_a = 2'b00; step();
        check_a("gap_idle", 32'h0000_A210, 4'b0000, 2'b01, 1'b1);
        in_a = 16'h0020; valid_a = 2'b01; step();
        check_a("gap2", 32'h0000_2010, 4'b0010, 2'b00, 1'b0);

        // Skew: channel 0 alone, then channel 1 alone.
        in_a = 16'h0033; valid_a = 2'b01; step();
        check_a("skew_on", 32'h0000_2033, 4'b0001, 2'b01, 1'b1);
        in_a = 16'h4400; valid_a = 2'b10; step();
        check_a("skew_off", 32'h0044_2033, 4'b0100, 2'b11, 1'b0);

        // Align with a byte while channel 0 sits at sel=1: lands on out0, sel=1.
        // Channel 1 has no byte so it realigns to 0, which is a disagreement.
        in_a = 16'h005A; valid_a = 2'b01; align = 1'b1; step();
        check_a("align_byte", 32'h0044_205A, 4'b0001, 2'b01, 1'b1);
        valid_a = 2'b00; step();
        check_a("align_clear", 32'h0044_205A, 4'b0000, 2'b00, 1'b0);
        align = 1'b0;

        // Both channels in lock-step keep skew low.
        in_a = 16'h6261; valid_a = 2'b11; step();
        check_a("both", 32'h0062_2061, 4'b0101, 2'b11, 1'b0);

        // Asynchronous reset mid-stream, away from any clock edge.
        in_a = 16'h7777; valid_a = 2'b11;
        #2 reset = 1'b0;
        #1;
        check_a("rst_async", 32'h0, 4'h0, 2'b00, 1'b0);
        step();
        check_a("rst_hold", 32'h0, 4'h0, 2'b00, 1'b0);
        valid_a = 2'b00;
        reset = 1'b1;
        step();
        check_a("rst_release", 32'h0, 4'h0, 2'b00, 1'b0);

        // FANOUT=3: seven bytes on channel 2 strobe outputs 6,7,8,6,7,8,6.
        valid_b = 3'b100;
        for (int b = 0; b < 7; b++) begin
            logic [7:0] byte_v;
            int         k;
            byte_v = 8'h71 + 8'(b);
            k      = 6 + (b % 3);
            in_b   = {byte_v, 16'h0000};
            step();
            check($sformatf("nf3_vout%0d", b), 64'(vo_b), 64'(9'b1 << k));
            check($sformatf("nf3_out%0d", b), 64'(out_b[k*8 +: 8]), 64'(byte_v));
            check($sformatf("nf3_sel%0d", b), 64'(sel_b), 64'({2'((b + 1) % 3), 4'b0000}));
            check($sformatf("nf3_range%0d", b), 64'(sel_b[5:4] < 2'd3), 64'(1));
            check($sformatf("nf3_skew%0d", b), 64'(skew_b), 64'(((b + 1) % 3) != 0));
        end
        valid_b = 3'b000;
        step();
        check("nf3_idle_vout", 64'(vo_b), 64'(0));
        check("nf3_idle_hold", 64'(out_b[71:48]), 64'(24'h767577));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
